// File: rtl/coin_accumulator.sv
// coin_accumulator
//   Upstream credit stage for vending_machine. Validates one coin event per
//   clock, accumulates the running credit and presents it on O_CHANGE. The
//   credit is cleared on a successful vend. It is refunded on cancel or on an
//   inactivity timeout. A coin is rejected if its code is invalid, if it would
//   overflow MAX_CREDIT, or if it arrives while the block is busy.
//
// Ports
//   I_CLK           system clock, rising edge
//   I_RESET         synchronous active-high reset
//   I_COIN_VALID    coin event strobe, one cycle per coin
//   I_COIN_TYPE     coin code 0..5 = 1,5,10,25,100,500 cents; 6,7 invalid
//   I_SUCCESS       vend-complete level from vending_machine
//   I_CANCEL        refund request (pulse or level)
//   O_CHANGE        current credit in cents
//   O_COIN_REJECT   one-cycle pulse, coin returned to the chute
//   O_REFUND        refund amount, valid while O_REFUND_VALID is high
//   O_REFUND_VALID  one-cycle refund pulse
//   O_BUSY          high in S_CLEAR / S_REFUND
//
// Handshake: all outputs are registered. A coin presented in cycle N is
// reflected on O_CHANGE or O_COIN_REJECT in cycle N+1. There is no
// back-pressure: a coin that cannot be taken is always rejected, never stalled.
module coin_accumulator #(
    parameter int MAX_CREDIT     = 2000,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CNT_W          = 16
) (
    input  logic        I_CLK,
    input  logic        I_RESET,
    input  logic        I_COIN_VALID,
    input  logic [2:0]  I_COIN_TYPE,
    input  logic        I_SUCCESS,
    input  logic        I_CANCEL,
    output logic [15:0] O_CHANGE,
    output logic        O_COIN_REJECT,
    output logic [15:0] O_REFUND,
    output logic        O_REFUND_VALID,
    output logic        O_BUSY
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_REFUND = 2'd2,
        S_CLEAR  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     change_q, change_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            reject_q, reject_d;
    logic [15:0]     refund_q, refund_d;
    logic            refund_valid_q, refund_valid_d;
    logic            busy_q, busy_d;

    logic [15:0]     coin_value;
    logic            code_ok;
    logic [16:0]     sum;
    logic            fits;
    logic            timeout;
    logic            coin_accept;

    // Coin value decode.
    always_comb begin
        coin_value = 16'd0;
        code_ok    = 1'b1;
        case (I_COIN_TYPE)
            3'd0:    coin_value = 16'd1;
            3'd1:    coin_value = 16'd5;
            3'd2:    coin_value = 16'd10;
            3'd3:    coin_value = 16'd25;
            3'd4:    coin_value = 16'd100;
            3'd5:    coin_value = 16'd500;
            default: code_ok    = 1'b0;
        endcase
    end

    // The sum is one bit wider so that the limit compare can never alias.
    assign sum     = {1'b0, change_q} + {1'b0, coin_value};
    assign fits    = (sum <= 17'(MAX_CREDIT));
    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d        = state_q;
        change_d       = change_q;
        cnt_d          = cnt_q;
        refund_d       = 16'd0;
        refund_valid_d = 1'b0;
        coin_accept    = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                // Cancel is ignored here because there is no credit to refund.
                if (I_SUCCESS) begin
                    state_d = S_CLEAR;
                end else if (I_COIN_VALID && code_ok && fits) begin
                    coin_accept = 1'b1;
                    change_d    = sum[15:0];
                    state_d     = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (I_SUCCESS) begin
                    state_d  = S_CLEAR;
                    change_d = 16'd0;
                    cnt_d    = '0;
                end else if (I_CANCEL || timeout) begin
                    state_d        = S_REFUND;
                    refund_d       = change_q;
                    refund_valid_d = 1'b1;
                    change_d       = 16'd0;
                    cnt_d          = '0;
                end else if (I_COIN_VALID && code_ok && fits) begin
                    coin_accept = 1'b1;
                    change_d    = sum[15:0];
                    cnt_d       = '0;
                end else if (cnt_q != {CNT_W{1'b1}}) begin
                    // A rejected coin does not count as activity.
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_REFUND: begin
                state_d  = S_IDLE;
                change_d = 16'd0;
                cnt_d    = '0;
            end
            S_CLEAR: begin
                change_d = 16'd0;
                cnt_d    = '0;
                if (!I_SUCCESS) state_d = S_IDLE;
            end
            default: begin
                state_d  = S_IDLE;
                change_d = 16'd0;
                cnt_d    = '0;
            end
        endcase

        reject_d = I_COIN_VALID && !coin_accept;
        busy_d   = (state_d == S_CLEAR) || (state_d == S_REFUND);
    end

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state_q        <= S_IDLE;
            change_q       <= 16'd0;
            cnt_q          <= '0;
            reject_q       <= 1'b0;
            refund_q       <= 16'd0;
            refund_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            change_q       <= change_d;
            cnt_q          <= cnt_d;
            reject_q       <= reject_d;
            refund_q       <= refund_d;
            refund_valid_q <= refund_valid_d;
            busy_q         <= busy_d;
        end
    end

    assign O_CHANGE       = change_q;
    assign O_COIN_REJECT  = reject_q;
    assign O_REFUND       = refund_q;
    assign O_REFUND_VALID = refund_valid_q;
    assign O_BUSY         = busy_q;

endmodule

// File: tb/tb_coin_accumulator.sv
// Testbench for coin_accumulator: directed scenarios and random traffic,
// checked every cycle against a behavioural credit model, plus an expected
// queue of refund amounts.
module tb_coin_accumulator;

    localparam int T    = 8;
    localparam int MAXC = 2000;

    logic        clk = 1'b0;
    logic        rst;
    logic        coin_valid;
    logic [2:0]  coin_type;
    logic        success;
    logic        cancel;
    logic [15:0] o_change;
    logic        o_reject;
    logic [15:0] o_refund;
    logic        o_refund_valid;
    logic        o_busy;

    always #5 clk = ~clk;

    coin_accumulator #(
        .MAX_CREDIT     (MAXC),
        .TIMEOUT_CYCLES (T),
        .CNT_W          (16)
    ) dut (
        .I_CLK          (clk),
        .I_RESET        (rst),
        .I_COIN_VALID   (coin_valid),
        .I_COIN_TYPE    (coin_type),
        .I_SUCCESS      (success),
        .I_CANCEL       (cancel),
        .O_CHANGE       (o_change),
        .O_COIN_REJECT  (o_reject),
        .O_REFUND       (o_refund),
        .O_REFUND_VALID (o_refund_valid),
        .O_BUSY         (o_busy)
    );

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q[$];

    // Behavioural model: credit in cents, idle cycles since last coin, and
    // whether the block is in a vend-clear or refund window.
    int vals[8] = '{1, 5, 10, 25, 100, 500, 0, 0};
    int m_credit, m_idle;
    bit m_clear, m_refund;
    int e_change, e_refund;
    bit e_reject, e_rv, e_busy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit taken;
        taken    = 1'b0;
        e_rv     = 1'b0;
        e_refund = 0;
        if (rst) begin
            m_credit = 0; m_idle = 0; m_clear = 0; m_refund = 0;
            e_change = 0; e_reject = 0; e_busy = 0;
            return;
        end
        if (m_refund) begin
            m_refund = 0;
        end else if (m_clear) begin
            if (!success) m_clear = 0;
        end else if (success) begin
            m_clear = 1; m_credit = 0; m_idle = 0;
        end else if (m_credit > 0 && (cancel || m_idle == T - 1)) begin
            e_rv = 1; e_refund = m_credit;
            exp_q.push_back(16'(m_credit));
            m_credit = 0; m_idle = 0; m_refund = 1;
        end else if (coin_valid && coin_type <= 5 && m_credit + vals[coin_type] <= MAXC) begin
            m_credit += vals[coin_type];
            m_idle = 0;
            taken = 1;
        end else if (m_credit > 0) begin
            m_idle++;
        end
        e_reject = coin_valid && !taken;
        e_change = m_credit;
        e_busy   = m_clear || m_refund;
    endtask

    task automatic compare_all();
        check("change", 32'(o_change), 32'(e_change));
        check("reject", 32'(o_reject), 32'(e_reject));
        check("refund", 32'(o_refund), 32'(e_refund));
        check("refund_valid", 32'(o_refund_valid), 32'(e_rv));
        check("busy", 32'(o_busy), 32'(e_busy));
        if (o_refund_valid) begin
            if (exp_q.size() == 0) check("refund_sb_empty", 32'd1, 32'd0);
            else check("refund_sb", 32'(o_refund), 32'(exp_q.pop_front()));
        end
    endtask

    // Drive one cycle of inputs, advance one edge, then compare.
    task automatic cyc(input bit s, input bit c, input bit v, input logic [2:0] t, input bit r = 1'b0);
        rst = r; success = s; cancel = c; coin_valid = v; coin_type = t;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic coin(input logic [2:0] t);
        cyc(0, 0, 1, t);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 3'd0);
    endtask

    int rv_at, rv_cnt;

    initial begin
        rst = 1'b1; success = 0; cancel = 0; coin_valid = 0; coin_type = 0;
        m_credit = 0; m_idle = 0; m_clear = 0; m_refund = 0;
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        check("reset_change", 32'(o_change), 32'd0);
        idle();

        // Consecutive coins 100, 25, 25.
        coin(3'd4); check("t1_c100", 32'(o_change), 32'd100);
        coin(3'd3); check("t1_c125", 32'(o_change), 32'd125);
        coin(3'd3); check("t1_c150", 32'(o_change), 32'd150);
        cyc(0, 1, 0, 0); idle(); idle();

        // Build 1900, overflow reject, then exactly the limit.
        for (int i = 0; i < 3; i++) coin(3'd5);
        for (int i = 0; i < 4; i++) coin(3'd4);
        check("t2_1900", 32'(o_change), 32'd1900);
        coin(3'd5);
        check("t2_ovf_reject", 32'(o_reject), 32'd1);
        check("t2_ovf_hold", 32'(o_change), 32'd1900);
        coin(3'd4);
        check("t2_at_limit", 32'(o_change), 32'd2000);
        check("t2_no_reject", 32'(o_reject), 32'd0);
        cyc(0, 1, 0, 0); idle(); idle();

        // Vend success with a coin in the same cycle.
        coin(3'd4); coin(3'd3); coin(3'd3); coin(3'd3);
        check("t3_175", 32'(o_change), 32'd175);
        cyc(1, 0, 1, 3'd3);
        check("t3_clear", 32'(o_change), 32'd0);
        check("t3_rej", 32'(o_reject), 32'd1);
        check("t3_busy1", 32'(o_busy), 32'd1);
        cyc(1, 0, 0, 0); check("t3_busy2", 32'(o_busy), 32'd1);
        cyc(1, 0, 0, 0); check("t3_busy3", 32'(o_busy), 32'd1);
        idle();          check("t3_busy_off", 32'(o_busy), 32'd0);
        idle();

        // Cancel held for 5 cycles: one refund of 260.
        coin(3'd4); coin(3'd4); coin(3'd3); coin(3'd3); coin(3'd2);
        rv_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 0, 0);
            if (o_refund_valid) begin
                rv_cnt++;
                check("t4_amount", 32'(o_refund), 32'd260);
            end
        end
        check("t4_one_pulse", 32'(rv_cnt), 32'd1);
        check("t4_after", 32'(o_change), 32'd0);

        // Timeout after 8 idle cycles.
        coin(3'd2);
        rv_at = 0;
        for (int k = 1; k <= 10; k++) begin
            idle();
            if (o_refund_valid && rv_at == 0) rv_at = k;
        end
        check("t5_timeout_at", 32'(rv_at), 32'd8);

        // Timeout restart by a second coin.
        coin(3'd2);
        rv_at = 0;
        for (int k = 1; k <= 16; k++) begin
            if (k == 6) coin(3'd1); else idle();
            if (o_refund_valid && rv_at == 0) begin
                rv_at = k;
                check("t5_restart_amt", 32'(o_refund), 32'd15);
            end
        end
        check("t5_restart_at", 32'(rv_at), 32'd14);

        // Invalid code and reset with credit.
        coin(3'd6);
        check("t6_code6", 32'(o_reject), 32'd1);
        coin(3'd4); coin(3'd4); coin(3'd4);
        check("t6_300", 32'(o_change), 32'd300);
        cyc(0, 0, 0, 0, 1);
        check("t6_rst_change", 32'(o_change), 32'd0);
        check("t6_rst_rv", 32'(o_refund_valid), 32'd0);
        idle();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom % 40) == 0, ($urandom % 30) == 0, ($urandom % 2) == 1,
                3'($urandom_range(0, 7)), ($urandom % 500) == 0);
        end
        idle(); idle();

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/coin_accumulator.md
Name: coin_accumulator

Overview:
Upstream credit stage for vending_machine. Accepts one coin event per clock, validates its denomination and accumulates the running credit. Drives the credit onto vending_machine I_CHANGE. Clears on a successful vend, refunds the credit on cancel or inactivity timeout, and rejects coins that are invalid or would overflow the credit limit.

Parameters:
MAX_CREDIT, 2000, highest credit in cents that may be held; a coin that would exceed it is rejected
TIMEOUT_CYCLES, 1000, number of idle clocks in S_ACCUM after the last accepted coin before an automatic refund
CNT_W, 16, width of the timeout counter; must satisfy TIMEOUT_CYCLES < 2^CNT_W

Ports:
I_CLK  input  1  system clock, rising edge
I_RESET  input  1  synchronous, active-high reset
I_COIN_VALID  input  1  coin event strobe, one cycle per coin
I_COIN_TYPE  input  3  coin code: 0=1, 1=5, 2=10, 3=25, 4=100, 5=500; codes 6 and 7 are invalid
I_SUCCESS  input  1  vend-complete level from vending_machine O_SUCCESS
I_CANCEL  input  1  refund request button, one-cycle pulse or level
O_CHANGE  output  16  current credit in cents; connects to vending_machine I_CHANGE
O_COIN_REJECT  output  1  one-cycle pulse: the coin is returned to the chute
O_REFUND  output  16  amount to refund; valid only while O_REFUND_VALID is high
O_REFUND_VALID  output  1  one-cycle refund pulse
O_BUSY  output  1  high in S_CLEAR and S_REFUND; coins are rejected while high

Behaviour:
- Reset: every output is 0, state is S_IDLE, timeout counter is 0. Reset mid-operation discards the credit with no refund pulse.
- All outputs are registered. A coin accepted in cycle N appears on O_CHANGE in cycle N+1. O_COIN_REJECT fires in cycle N+1.
- Coin value decode is combinational from I_COIN_TYPE. Sum = O_CHANGE + value, computed at 17 bits.
- Coin accept condition: I_COIN_VALID=1, code ≤ 5, Sum ≤ MAX_CREDIT, and state is S_IDLE or S_ACCUM.
  - Any other coin with I_COIN_VALID=1 is rejected; O_CHANGE is unchanged.
  - Sum == MAX_CREDIT is accepted.
- Priority within one cycle: I_SUCCESS > I_CANCEL > coin. A coin arriving in the same cycle as I_SUCCESS or an acted-on I_CANCEL is rejected.
- States:
  - S_IDLE (credit 0):
    - Accepted coin → S_ACCUM.
    - I_CANCEL is ignored (no refund pulse).
    - I_SUCCESS → S_CLEAR.
  - S_ACCUM:
    - Accepted coin adds its value and clears the timeout counter.
    - No coin: the counter increments.
    - I_SUCCESS → S_CLEAR; O_CHANGE←0 next cycle.
    - I_CANCEL, or counter == TIMEOUT_CYCLES-1 → S_REFUND.
  - S_REFUND (one cycle):
    - O_REFUND = credit at entry and O_REFUND_VALID=1 for exactly this cycle.
    - O_CHANGE=0 in this cycle.
    - Then → S_IDLE. O_REFUND returns to 0 the next cycle.
  - S_CLEAR:
    - O_CHANGE=0. Stays while I_SUCCESS=1 and → S_IDLE on the first cycle I_SUCCESS=0.
    - Coins are rejected and I_CANCEL is ignored.
- vending_machine computes and dispenses the change due; this block never subtracts a price.
- I_CANCEL held high: only one refund is produced, because the credit is 0 after S_REFUND and S_IDLE ignores cancel.
- The timeout counter saturates; it does not wrap. It is cleared on every entry to S_IDLE.

Test Plan:
1. Reset, then coins 100, 25, 25 on consecutive cycles → O_CHANGE reads 100, 125, 150 in cycles 1..3 after each coin; no rejects.
2. Credit 1900, then a 500 coin → O_COIN_REJECT pulses once and O_CHANGE stays 1900. Then a 100 coin → O_CHANGE=2000, accepted at the limit.
3. Credit 175, then I_SUCCESS high for 3 cycles with a 25 coin in its first cycle → O_CHANGE=0 next cycle, the coin is rejected, O_BUSY=1 for 3 cycles, and the block returns to S_IDLE when I_SUCCESS falls.
4. Credit 260, then I_CANCEL held for 5 cycles → a single O_REFUND_VALID pulse with O_REFUND=260; O_CHANGE=0 afterwards.
5. TIMEOUT_CYCLES=8: one 10 coin, then no activity → a refund of 10 exactly 8 cycles after the coin is registered. Repeat with a coin at cycle 6 → the counter restarts and the refund amount includes both coins.
6. Coin code 6 → rejected. I_RESET asserted with credit 300 → all outputs 0 next cycle, no refund pulse.
